// File: rtl/rr_req_queue.sv
// Two-client request front-end for the round-robin arbiter: per-client FIFOs raise
// ir0/ir1 while non-empty and pop onto one shared output port on each sampled grant.
module rr_req_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push0,
  input  logic [WIDTH-1:0] data0,
  output logic             full0,
  input  logic             push1,
  input  logic [WIDTH-1:0] data1,
  output logic             full1,
  output logic             ir0,
  output logic             ir1,
  input  logic             ack0,
  input  logic             ack1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic [1:0]       ovf,
  output logic             err_mutex
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [AW-1:0]    rd_ptr [2];
  logic [AW-1:0]    wr_ptr [2];
  logic [CW-1:0]    cnt    [2];
  logic [WIDTH-1:0] wdata  [2];

  logic [1:0] push_in;
  logic [1:0] ack_in;
  logic [1:0] nonempty;
  logic [1:0] is_full;
  logic [1:0] pop;
  logic [1:0] wr_en;
  logic [1:0] drop;
  logic       both_ack;

  assign push_in  = {push1, push0};
  assign ack_in   = {ack1, ack0};
  assign wdata[0] = data0;
  assign wdata[1] = data1;
  assign both_ack = ack0 & ack1;

  // A full FIFO still accepts a push when it pops at the same edge.
  always_comb begin
    nonempty = '0;
    is_full  = '0;
    pop      = '0;
    wr_en    = '0;
    drop     = '0;
    for (int n = 0; n < 2; n++) begin
      nonempty[n] = (cnt[n] != '0);
      is_full[n]  = (cnt[n] == FULL_CNT);
      pop[n]      = ack_in[n] & ~both_ack & nonempty[n];
      wr_en[n]    = push_in[n] & (~is_full[n] | pop[n]);
      drop[n]     = push_in[n] & is_full[n] & ~pop[n];
    end
  end

  assign ir0   = nonempty[0];
  assign ir1   = nonempty[1];
  assign full0 = is_full[0];
  assign full1 = is_full[1];

  // Storage is not reset; only occupancy decides what is visible.
  always_ff @(posedge clock) begin
    for (int n = 0; n < 2; n++) begin
      if (wr_en[n]) mem[n][wr_ptr[n]] <= wdata[n];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        rd_ptr[n] <= '0;
        wr_ptr[n] <= '0;
        cnt[n]    <= '0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      ovf       <= '0;
      err_mutex <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (pop[n])   rd_ptr[n] <= rd_ptr[n] + AW'(1);
        if (wr_en[n]) wr_ptr[n] <= wr_ptr[n] + AW'(1);
        if (wr_en[n] && !pop[n])      cnt[n] <= cnt[n] + CW'(1);
        else if (pop[n] && !wr_en[n]) cnt[n] <= cnt[n] - CW'(1);
      end
      ovf       <= ovf | drop;
      if (both_ack) err_mutex <= 1'b1;
      out_valid <= |pop;
      if (pop[0]) begin
        out_data <= mem[0][rd_ptr[0]];
        out_src  <= 1'b0;
      end else if (pop[1]) begin
        out_data <= mem[1][rd_ptr[1]];
        out_src  <= 1'b1;
      end
    end
  end

endmodule
